// File: rtl/sram_responder.sv
// sram_responder: target side of the core's 16-bit memory port.
// It services one request at a time on an external asynchronous 256K x 16 SRAM.
// WAIT_CYCLES sets the number of extra access cycles. Read data is returned
// together with a single-cycle m_a_ack. Every output is registered. The
// data-bus drive enable (dq_oe) is also a register, so no output glitches
// combinationally.
module sram_responder #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] m_a_adr,
  input  logic        m_a_req,
  output logic        m_a_ack,
  input  logic        m_a_write,
  input  logic [1:0]  m_a_sel,
  input  logic [15:0] m_a_wdata,
  output logic [15:0] m_a_rdata,
  output logic [17:0] sram_addr,
  inout  logic [15:0] sram_dq,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Wait-state reload value. The legal range 0..15 fits in four bits.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nx_s;
  logic        write_r;
  logic        write_nx_s;
  logic [15:0] wdata_r;
  logic [15:0] wdata_nx_s;
  logic        dq_oe;
  logic        dq_oe_nx_s;
  logic        ack_nx_s;
  logic [15:0] rdata_nx_s;
  logic [17:0] addr_nx_s;
  logic        ce_n_nx_s;
  logic        oe_n_nx_s;
  logic        we_n_nx_s;
  logic        ub_n_nx_s;
  logic        lb_n_nx_s;

  // The SRAM data bus is driven only from the latched write data, and only
  // while the registered enable is set.
  assign sram_dq = dq_oe ? wdata_r : 16'hzzzz;

  // State register, which also holds every registered output and latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      write_r   <= 1'b0;
      wdata_r   <= 16'h0000;
      dq_oe     <= 1'b0;
      m_a_ack   <= 1'b0;
      m_a_rdata <= 16'h0000;
      sram_addr <= 18'h00000;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      write_r   <= write_nx_s;
      wdata_r   <= wdata_nx_s;
      dq_oe     <= dq_oe_nx_s;
      m_a_ack   <= ack_nx_s;
      m_a_rdata <= rdata_nx_s;
      sram_addr <= addr_nx_s;
      sram_ce_n <= ce_n_nx_s;
      sram_oe_n <= oe_n_nx_s;
      sram_we_n <= we_n_nx_s;
      sram_ub_n <= ub_n_nx_s;
      sram_lb_n <= lb_n_nx_s;
    end
  end

  // Next-state and next-output logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    write_nx_s = write_r;
    wdata_nx_s = wdata_r;
    dq_oe_nx_s = dq_oe;
    ack_nx_s   = 1'b0;
    rdata_nx_s = m_a_rdata;
    addr_nx_s  = sram_addr;
    ce_n_nx_s  = sram_ce_n;
    oe_n_nx_s  = sram_oe_n;
    we_n_nx_s  = sram_we_n;
    ub_n_nx_s  = sram_ub_n;
    lb_n_nx_s  = sram_lb_n;

    case (state_r)
      ST_IDLE: begin
        // IDLE is also the bus turnaround. Nothing is strobed and nothing
        // is driven here.
        ce_n_nx_s  = 1'b1;
        oe_n_nx_s  = 1'b1;
        we_n_nx_s  = 1'b1;
        ub_n_nx_s  = 1'b1;
        lb_n_nx_s  = 1'b1;
        dq_oe_nx_s = 1'b0;
        if (m_a_req) begin
          addr_nx_s  = m_a_adr;
          write_nx_s = m_a_write;
          wdata_nx_s = m_a_wdata;
          cnt_nx_s   = WAIT_LOAD;
          ce_n_nx_s  = 1'b0;
          state_nx_s = ST_ACCESS;
          if (m_a_write) begin
            // An empty lane mask still runs the full cycle but never pulses we_n.
            we_n_nx_s  = (m_a_sel == 2'b00);
            ub_n_nx_s  = ~m_a_sel[1];
            lb_n_nx_s  = ~m_a_sel[0];
            dq_oe_nx_s = 1'b1;
          end else begin
            // Reads always fetch the full word, whatever the lane mask says.
            oe_n_nx_s = 1'b0;
            ub_n_nx_s = 1'b0;
            lb_n_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_r != 4'd0) begin
          cnt_nx_s = cnt_r - 4'd1;
        end else begin
          // Last access cycle: release every strobe, complete the transfer
          // and capture read data from the bus on the same edge.
          state_nx_s = ST_DONE;
          ce_n_nx_s  = 1'b1;
          oe_n_nx_s  = 1'b1;
          we_n_nx_s  = 1'b1;
          ub_n_nx_s  = 1'b1;
          lb_n_nx_s  = 1'b1;
          ack_nx_s   = 1'b1;
          if (!write_r) begin
            rdata_nx_s = sram_dq;
          end else begin
            rdata_nx_s = m_a_rdata;
          end
        end
      end

      ST_DONE: begin
        // dq_oe stayed set through this cycle, so write data is held after
        // the we_n rise. It is released on the way back to IDLE.
        ack_nx_s   = 1'b0;
        dq_oe_nx_s = 1'b0;
        state_nx_s = ST_IDLE;
      end

      default: begin
        state_nx_s = ST_IDLE;
        ce_n_nx_s  = 1'b1;
        oe_n_nx_s  = 1'b1;
        we_n_nx_s  = 1'b1;
        ub_n_nx_s  = 1'b1;
        lb_n_nx_s  = 1'b1;
        dq_oe_nx_s = 1'b0;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder. It runs three instances with WAIT_CYCLES of 1, 0 and 3.
// Each instance has its own behavioural SRAM. A scoreboard queue of expected acks
// is checked by an independent monitor.
`timescale 1ns/1ps
module tb_sram_responder;

  typedef struct {
    int          inst;
    int          ack_cyc;
    bit          rd;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [2:0]        req;
  logic [17:0]       adr;
  logic              wr;
  logic [1:0]        sel;
  logic [15:0]       wdata;
  logic [2:0]        ack, ce_n, oe_n, we_n, ub_n, lb_n;
  logic [2:0][15:0]  rdata;
  logic [2:0][17:0]  saddr;
  wire  [15:0]       dq0, dq1, dq2;
  logic [2:0][15:0]  dqv;
  logic [2:0]        doe;
  logic [15:0]       mem [3][256];
  logic [15:0]       last_rd [3];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   overlap = 0;
  exp_t sbq [$];
  exp_t mon_e;

  sram_responder #(.WAIT_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .m_a_adr(adr), .m_a_req(req[0]), .m_a_ack(ack[0]),
    .m_a_write(wr), .m_a_sel(sel), .m_a_wdata(wdata), .m_a_rdata(rdata[0]),
    .sram_addr(saddr[0]), .sram_dq(dq0), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0]));

  sram_responder #(.WAIT_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .m_a_adr(adr), .m_a_req(req[1]), .m_a_ack(ack[1]),
    .m_a_write(wr), .m_a_sel(sel), .m_a_wdata(wdata), .m_a_rdata(rdata[1]),
    .sram_addr(saddr[1]), .sram_dq(dq1), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1]));

  sram_responder #(.WAIT_CYCLES(3)) u2 (
    .clk(clk), .rst(rst), .m_a_adr(adr), .m_a_req(req[2]), .m_a_ack(ack[2]),
    .m_a_write(wr), .m_a_sel(sel), .m_a_wdata(wdata), .m_a_rdata(rdata[2]),
    .sram_addr(saddr[2]), .sram_dq(dq2), .sram_ce_n(ce_n[2]), .sram_oe_n(oe_n[2]),
    .sram_we_n(we_n[2]), .sram_ub_n(ub_n[2]), .sram_lb_n(lb_n[2]));

  // SRAM models: each drives its bus while selected for a read.
  assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem[0][saddr[0][7:0]] : 16'hzzzz;
  assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem[1][saddr[1][7:0]] : 16'hzzzz;
  assign dq2 = (!ce_n[2] && !oe_n[2] && we_n[2]) ? mem[2][saddr[2][7:0]] : 16'hzzzz;
  assign dqv = {dq2, dq1, dq0};
  assign doe = {u2.dq_oe, u1.dq_oe, u0.dq_oe};

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: write the enabled lanes while we_n and ce_n are low.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!ce_n[i] && !we_n[i]) begin
        if (!ub_n[i]) mem[i][saddr[i][7:0]][15:8] <= dqv[i][15:8];
        if (!lb_n[i]) mem[i][saddr[i][7:0]][7:0]  <= dqv[i][7:0];
      end
    end
  end

  // Bus-turnaround watch: the block must never drive while the SRAM outputs.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (doe[i] && !oe_n[i]) overlap <= overlap + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the scoreboard and checks instance, cycle and data.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ack[i]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: inst %0d acked at cycle %0d with nothing outstanding", i, cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("ack_instance", i, mon_e.inst);
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk(mon_e.rd ? "read_data" : "rdata_retained", rdata[i], mon_e.rdata);
        end
      end
    end
  end

  // Issue one transfer on instance i with wait states w. The call is made at a
  // negedge. lag=0 means the DUT samples req in the current cycle; lag=1 means
  // it is in DONE and samples in the next one. Returns at the ack negedge.
  task automatic xfer(input int i, input int w, input bit wr_i, input logic [17:0] a,
                      input logic [1:0] s_i, input logic [15:0] d, input logic [15:0] exp_rd,
                      input int lag, input bit keep);
    int   s;
    int   we_lo;
    int   oe_lo;
    int   drv;
    int   lane_bad;
    int   addr_bad;
    bit   got;
    exp_t e;
    adr    = a;
    wr     = wr_i;
    sel    = s_i;
    wdata  = d;
    req[i] = 1'b1;
    s = cyc + lag;
    e.inst    = i;
    e.ack_cyc = s + w + 2;
    e.rd      = !wr_i;
    e.rdata   = wr_i ? last_rd[i] : exp_rd;
    if (!wr_i) last_rd[i] = exp_rd;
    sbq.push_back(e);
    we_lo = 0; oe_lo = 0; drv = 0; lane_bad = 0; addr_bad = 0; got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if ((cyc - s) >= 1 && (cyc - s) <= (w + 2) && saddr[i] !== a) addr_bad++;
      if (!we_n[i]) begin
        we_lo++;
        if (ub_n[i] !== ~s_i[1] || lb_n[i] !== ~s_i[0]) lane_bad++;
      end
      if (!oe_n[i]) begin
        oe_lo++;
        if (ub_n[i] !== 1'b0 || lb_n[i] !== 1'b0) lane_bad++;
      end
      if (doe[i]) drv++;
      if (ack[i]) got = 1'b1;
    end
    if (!keep) req[i] = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: inst %0d no ack within 40 cycles", i);
    end
    chk("we_n_low_cycles", we_lo, (wr_i && s_i != 2'b00) ? w + 1 : 0);
    chk("oe_n_low_cycles", oe_lo, wr_i ? 0 : w + 1);
    chk("dq_driven_cycles", drv, wr_i ? w + 2 : 0);
    chk("byte_lanes", lane_bad, 0);
    chk("addr_stable", addr_bad, 0);
  endtask

  int bad;

  initial begin
    rst = 1'b1;
    req = 3'b000;
    adr = 18'h00000; wr = 1'b0; sel = 2'b00; wdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 16'h0000;
      for (int j = 0; j < 256; j++) mem[i][j] = 16'h0000;
    end
    // Reset held for 3 cycles with a write request pending.
    adr = 18'h00010; wr = 1'b1; sel = 2'b11; wdata = 16'hBEEF; req[0] = 1'b1;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack[0] !== 1'b0 || rdata[0] !== 16'h0000) bad++;
    end
    chk("reset_ack_rdata", bad, 0);
    chk("reset_strobes", {ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0]}, 5'b11111);
    chk("reset_dq_released", doe[0], 1'b0);
    rst = 1'b0;

    // W=1: full-word write then read, the first one straight out of reset.
    xfer(0, 1, 1'b1, 18'h00010, 2'b11, 16'hBEEF, 16'h0000, 0, 1'b0);
    @(negedge clk);
    xfer(0, 1, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'hBEEF, 0, 1'b0);
    // Byte lanes.
    @(negedge clk);
    xfer(0, 1, 1'b1, 18'h00010, 2'b10, 16'h12AA, 16'h0000, 0, 1'b0);
    @(negedge clk);
    xfer(0, 1, 1'b0, 18'h00010, 2'b00, 16'h0000, 16'h12EF, 0, 1'b0);
    @(negedge clk);
    xfer(0, 1, 1'b1, 18'h00010, 2'b01, 16'h5534, 16'h0000, 0, 1'b0);
    @(negedge clk);
    xfer(0, 1, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'h1234, 0, 1'b0);
    // Back-to-back with req held high.
    @(negedge clk);
    xfer(0, 1, 1'b1, 18'h00020, 2'b11, 16'h0001, 16'h0000, 0, 1'b1);
    xfer(0, 1, 1'b1, 18'h00021, 2'b11, 16'h0002, 16'h0000, 1, 1'b1);
    xfer(0, 1, 1'b0, 18'h00020, 2'b11, 16'h0000, 16'h0001, 1, 1'b1);
    xfer(0, 1, 1'b0, 18'h00021, 2'b11, 16'h0000, 16'h0002, 1, 1'b0);

    // W=0: preload, empty write, then readback shows memory unchanged.
    @(negedge clk);
    xfer(1, 0, 1'b1, 18'h00010, 2'b11, 16'hA5A5, 16'h0000, 0, 1'b0);
    @(negedge clk);
    xfer(1, 0, 1'b1, 18'h00010, 2'b00, 16'hFFFF, 16'h0000, 0, 1'b0);
    @(negedge clk);
    xfer(1, 0, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'hA5A5, 0, 1'b0);

    // W=3: good write, then a write aborted by reset in its first access cycle.
    @(negedge clk);
    xfer(2, 3, 1'b1, 18'h00010, 2'b11, 16'hCAFE, 16'h0000, 0, 1'b0);
    @(negedge clk);
    adr = 18'h00011; wr = 1'b1; sel = 2'b11; wdata = 16'h7777; req[2] = 1'b1;
    @(negedge clk);
    chk("abort_in_access", {ce_n[2], we_n[2]}, 2'b00);
    rst = 1'b1;
    req[2] = 1'b0;
    @(negedge clk);
    chk("abort_strobes_high", {ce_n[2], oe_n[2], we_n[2]}, 3'b111);
    chk("abort_dq_released", doe[2], 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) last_rd[i] = 16'h0000;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack[2]) bad++;
    end
    chk("abort_no_ack", bad, 0);
    xfer(2, 3, 1'b0, 18'h00010, 2'b11, 16'h0000, 16'hCAFE, 0, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("dq_oe_with_oe_n", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
